avm_vram_writer: RTL and testbench

AVM_VRAM_WRITER -- requirements
Module: avm_vram_writer

---
 rtl/vram_writer_pkg.sv | 17 +
 rtl/avm_vram_writer.sv | 130 +++++++++++++
 tb/tb_avm_vram_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vram_writer_pkg.sv
// Shared types and constants for the VRAM burst writer.
// WAIT_VS exists only when VRAM_WRITER_VSYNC_EN is defined.
package vram_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
`ifdef VRAM_WRITER_VSYNC_EN
        WAIT_VS,
`endif
        WRITE,
        DONE
    } state_t;

    localparam int unsigned VRAM_WORDS   = 600;
    localparam logic [9:0]  PALETTE_BASE = 10'h200;

endpackage

// File: rtl/avm_vram_writer.sv
// Avalon-MM burst writer: fills or ramps a run of VRAM words per command.
// Define VRAM_WRITER_VSYNC_EN to hold each burst until a rising edge of vs.
module avm_vram_writer
    import vram_writer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_incr,
    input  logic              vs,
    output logic              busy,
    output logic              done,
    output logic              AVM_CS,
    output logic              AVM_WRITE,
    output logic              AVM_READ,
    output logic [3:0]        AVM_BYTE_EN,
    output logic [ADDR_W-1:0] AVM_ADDR,
    output logic [DATA_W-1:0] AVM_WRITEDATA,
    input  logic              AVM_WAITREQUEST
);

    state_t            state;
    logic [ADDR_W-1:0] remaining;
    logic              incr_q;

    assign AVM_CS      = AVM_WRITE;
    assign AVM_READ    = 1'b0;
    assign AVM_BYTE_EN = 4'b1111;

`ifdef VRAM_WRITER_VSYNC_EN
    logic vs_r1, vs_r2;
    logic vs_rise;

    assign vs_rise = vs_r1 & ~vs_r2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_r1 <= 1'b0;
            vs_r2 <= 1'b0;
        end else begin
            vs_r1 <= vs;
            vs_r2 <= vs_r1;
        end
    end
`else
    logic unused_vs;
    assign unused_vs = vs;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            AVM_WRITE     <= 1'b0;
            AVM_ADDR      <= '0;
            AVM_WRITEDATA <= '0;
            remaining     <= '0;
            incr_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        AVM_ADDR      <= cmd_addr;
                        AVM_WRITEDATA <= cmd_data;
                        remaining     <= cmd_count;
                        incr_q        <= cmd_incr;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        if (cmd_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
`ifdef VRAM_WRITER_VSYNC_EN
                            state <= WAIT_VS;
`else
                            state     <= WRITE;
                            AVM_WRITE <= 1'b1;
`endif
                        end
                    end
                end
`ifdef VRAM_WRITER_VSYNC_EN
                WAIT_VS: begin
                    if (vs_rise) begin
                        state     <= WRITE;
                        AVM_WRITE <= 1'b1;
                    end
                end
`endif
                WRITE: begin
                    // Strobe, address and data only move once the slave takes the word.
                    if (!AVM_WAITREQUEST) begin
                        AVM_ADDR  <= AVM_ADDR + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                        if (incr_q)
                            AVM_WRITEDATA <= AVM_WRITEDATA + DATA_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state     <= DONE;
                            AVM_WRITE <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    AVM_WRITE <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avm_vram_writer.sv
// Directed bench for avm_vram_writer; follows VRAM_WRITER_VSYNC_EN when defined.
module tb_avm_vram_writer;
    import vram_writer_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [ADDR_W-1:0] cmd_count = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cmd_incr = 1'b0;
    logic              vs = 1'b0;
    logic              busy, done;
    logic              AVM_CS, AVM_WRITE, AVM_READ;
    logic [3:0]        AVM_BYTE_EN;
    logic [ADDR_W-1:0] AVM_ADDR;
    logic [DATA_W-1:0] AVM_WRITEDATA;
    logic              AVM_WAITREQUEST = 1'b0;

    int unsigned n_pass = 0;
    int unsigned n_checks = 0;
    int unsigned n_wr;

    always #5 CLK = ~CLK;

    avm_vram_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count),
        .cmd_data(cmd_data), .cmd_incr(cmd_incr), .vs(vs),
        .busy(busy), .done(done),
        .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_READ(AVM_READ),
        .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_ADDR(AVM_ADDR),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        check({tag, "_write"}, {63'd0, AVM_WRITE}, 64'd1);
        check({tag, "_cs"},    {63'd0, AVM_CS},    64'd1);
        check({tag, "_addr"},  {54'd0, AVM_ADDR},  {54'd0, a});
        check({tag, "_data"},  {32'd0, AVM_WRITEDATA}, {32'd0, d});
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_done"},  {63'd0, done},      64'd1);
        check({tag, "_nowr"},  {63'd0, AVM_WRITE}, 64'd0);
        check({tag, "_busy"},  {63'd0, busy},      64'd1);
        tick();
        check({tag, "_done_end"}, {63'd0, done},      64'd0);
        check({tag, "_ready"},    {63'd0, cmd_ready}, 64'd1);
        check({tag, "_idle"},     {63'd0, busy},      64'd0);
    endtask

    // Returns in the first cycle AVM_WRITE is expected high (or DONE for count 0).
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic inc);
        check("ready_pre_accept", {63'd0, cmd_ready}, 64'd1);
        cmd_addr = a; cmd_count = c; cmd_data = d; cmd_incr = inc;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
`ifdef VRAM_WRITER_VSYNC_EN
        if (c != '0) begin
            for (int i = 0; i < 3; i++) begin
                check("vs_wait_nowr", {63'd0, AVM_WRITE}, 64'd0);
                check("vs_wait_busy", {63'd0, busy}, 64'd1);
                tick();
            end
            vs = 1'b1;
            tick();
            check("vs_sampled_nowr", {63'd0, AVM_WRITE}, 64'd0);
            vs = 1'b0;
            tick();
        end
`endif
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_busy",  {63'd0, busy},      64'd0);
        check("rst_done",  {63'd0, done},      64'd0);
        check("rst_write", {63'd0, AVM_WRITE}, 64'd0);
        check("rst_cs",    {63'd0, AVM_CS},    64'd0);
        check("rst_addr",  {54'd0, AVM_ADDR},  64'd0);
        check("rst_data",  {32'd0, AVM_WRITEDATA}, 64'd0);
        check("tie_read",  {63'd0, AVM_READ},  64'd0);
        check("tie_be",    {60'd0, AVM_BYTE_EN}, 64'hF);
        RESET = 1'b0;
        tick();

        // Constant fill of the whole text screen
        issue(10'h000, ADDR_W'(VRAM_WORDS), 32'h20202020, 1'b0);
        for (int i = 0; i < VRAM_WORDS; i++) begin
            expect_word("fill", ADDR_W'(i), 32'h20202020);
            tick();
        end
        expect_done("fill");

        // Ramp with a two-cycle stall on the second word
        n_wr = 0;
        issue(10'h010, 10'd3, 32'd5, 1'b1);
        expect_word("stall_w1", 10'h010, 32'd5);
        n_wr += AVM_WRITE;
        tick();
        expect_word("stall_w2", 10'h011, 32'd6);
        n_wr += AVM_WRITE;
        AVM_WAITREQUEST = 1'b1;
        tick();
        expect_word("stall_hold1", 10'h011, 32'd6);
        n_wr += AVM_WRITE;
        tick();
        expect_word("stall_hold2", 10'h011, 32'd6);
        n_wr += AVM_WRITE;
        AVM_WAITREQUEST = 1'b0;
        tick();
        expect_word("stall_w3", 10'h012, 32'd7);
        n_wr += AVM_WRITE;
        tick();
        n_wr += AVM_WRITE;
        check("stall_write_cycles", 64'(n_wr), 64'd5);
        expect_done("stall");

        // Zero-length command writes nothing
        issue(10'h055, 10'd0, 32'hDEAD, 1'b0);
        check("zero_ready_low", {63'd0, cmd_ready}, 64'd0);
        expect_done("zero");

        // Address wraps past the top word
        issue(10'h3FF, 10'd2, 32'hA, 1'b1);
        expect_word("wrap_w1", 10'h3FF, 32'hA);
        tick();
        expect_word("wrap_w2", 10'h000, 32'hB);
        tick();
        expect_done("wrap");

        // Reset during the 4th word of a 10-word burst
        issue(10'h100, 10'd10, 32'd0, 1'b1);
        tick();
        tick();
        tick();
        expect_word("rstmid_w4", 10'h103, 32'd3);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("rstmid_write", {63'd0, AVM_WRITE}, 64'd0);
        check("rstmid_busy",  {63'd0, busy},      64'd0);
        check("rstmid_ready", {63'd0, cmd_ready}, 64'd1);
        check("rstmid_addr",  {54'd0, AVM_ADDR},  64'd0);
        issue(10'h020, 10'd1, 32'h77, 1'b0);
        expect_word("post_rst_w1", 10'h020, 32'h77);
        tick();
        expect_done("post_rst");

        // Palette block; a second request mid-burst is ignored
        issue(PALETTE_BASE, 10'd8, 32'h100, 1'b1);
        for (int i = 0; i < 8; i++) begin
            expect_word("pal", PALETTE_BASE + ADDR_W'(i), 32'h100 + 32'(i));
            check("pal_bit9", {63'd0, AVM_ADDR[9]}, 64'd1);
            check("pal_ready_low", {63'd0, cmd_ready}, 64'd0);
            if (i == 2) begin
                cmd_addr = 10'h0AA; cmd_count = 10'd1; cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
        expect_done("pal");
        tick();
        check("pal_no_queue", {63'd0, AVM_WRITE}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
